oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 127 ++++++++++++
 1 files changed

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma
// Purpose  : Sprite OAM DMA engine; halts the CPU and copies one memory page
//            into OAM, one byte per read/write tick pair.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma #(
    parameter logic [15:0] DMA_REG = 16'h4014,
    parameter int          PAGES   = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_tick,
    input  logic        wreq,
    input  logic [15:0] eawr,
    input  logic [7:0]  din,
    input  logic [7:0]  oam_base,
    output logic        halt,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_we,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic [7:0] c_last_idx = 8'(PAGES - 1);

    state_t      r_state;
    logic        r_parity;
    logic [7:0]  r_page;
    logic [7:0]  r_obase;
    logic [7:0]  r_idx;
    logic        r_halt;
    logic        r_busy;
    logic        r_mem_rd;
    logic        r_oam_we;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_oam_addr;
    logic [7:0]  r_oam_data;

    logic w_dma_write;
    assign w_dma_write = wreq && (eawr == DMA_REG);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_parity   <= 1'b0;
            r_page     <= 8'h00;
            r_obase    <= 8'h00;
            r_idx      <= 8'h00;
            r_halt     <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_oam_we   <= 1'b0;
            r_mem_addr <= 16'h0000;
            r_oam_addr <= 8'h00;
            r_oam_data <= 8'h00;
        end else begin
            // The write strobe is a single clk even when ticks are sparse.
            r_oam_we <= 1'b0;
            if (cpu_tick) begin
                r_parity <= ~r_parity;
                case (r_state)
                    S_IDLE: begin
                        if (w_dma_write) begin
                            r_page  <= din;
                            r_obase <= oam_base;
                            r_idx   <= 8'h00;
                            r_halt  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_HALT;
                        end
                    end
                    S_HALT: begin
                        r_state <= r_parity ? S_ALIGN : S_READ;
                    end
                    S_ALIGN: begin
                        r_state <= S_READ;
                    end
                    S_READ: begin
                        r_mem_addr <= {r_page, r_idx};
                        r_mem_rd   <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                    S_WRITE: begin
                        r_mem_rd   <= 1'b0;
                        r_oam_data <= mem_data;
                        r_oam_addr <= r_obase + r_idx;
                        r_oam_we   <= 1'b1;
                        if (r_idx == c_last_idx) begin
                            r_halt  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= S_READ;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign halt     = r_halt;
    assign busy     = r_busy;
    assign mem_addr = r_mem_addr;
    assign mem_rd   = r_mem_rd;
    assign oam_addr = r_oam_addr;
    assign oam_data = r_oam_data;
    assign oam_we   = r_oam_we;

endmodule
`default_nettype wire
